fsm_prog_loader: RTL and testbench
==================================

Name: fsm_prog_loader

Overview:
- Upstream feeder for the programmable FSM `Controller`.
- Accepts transition-table bytes over a valid/ready byte interface and serialises them LSB-first onto the `Controller`'s `prog_enable`/`prog_data` pair, one bit per cycle.
- Counts bits until the full table (`TABLE_BITS`) has been shifted, then signals `done`.
- Sits between the chip I/O (`uio_in` byte bus) and the `Controller` programming inputs.

Parameters:
- STATE_COUNT, 8, number of FSM states in the downstream `Controller`.
- STATE_WIDTH, $clog2(STATE_COUNT), width of one state encoding.
- TABLE_BITS, 2*STATE_COUNT*STATE_WIDTH (48 at defaults), total programming bits to shift. Must be ≥1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- byte_data  in  8  programming byte; bit 0 is shifted first.
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- prog_enable  out  1  prog_data carries a valid programming bit this cycle.
- prog_data  out  1  current programming bit.
- busy  out  1  load in progress (WAIT_BYTE or SHIFT).
- done  out  1  full table shifted; held until next start or reset.
- bit_count  out  $clog2(TABLE_BITS+1)  number of bits emitted so far in the current load.

Behaviour:
- Clock and reset: one clock (`clock`); reset `rst_n` is synchronous and active-low. `rst_n`=0 at an edge → state IDLE, shift register 0, bit_count 0, byte index 0. All outputs 0 (prog_enable, prog_data, byte_ready, busy, done).
- Handshake: transfer occurs when byte_valid && byte_ready at a rising edge. byte_data may change freely when no transfer occurs.
- State IDLE:
  - byte_ready=0.
  - start=1 → WAIT_BYTE; bit_count := 0.
- State WAIT_BYTE:
  - byte_ready=1, busy=1, prog_enable=0.
  - On transfer: shreg := byte_data, bits_left := min(8, TABLE_BITS-bit_count), then → SHIFT.
- State SHIFT:
  - prog_enable=1, prog_data=shreg[0], busy=1.
  - Each cycle: shreg shifts right by 1, bit_count increments, bits_left decrements.
- Last bit of a byte, more bits remaining (bits_left==1, bit_count+1<TABLE_BITS):
  - byte_ready=1 in this cycle.
  - Transfer in this cycle → new byte loaded; SHIFT continues with no gap (back-to-back stream).
  - No transfer → WAIT_BYTE.
- Last table bit (bit_count+1==TABLE_BITS):
  - byte_ready=0 → DONE.
  - Remaining bits of a partial final byte are discarded.
- State DONE:
  - done=1, busy=0, byte_ready=0, prog_enable=0, bit_count holds TABLE_BITS.
  - start=1 → WAIT_BYTE; done:=0, bit_count:=0.
- Latency: byte accepted at edge N → its bit0 presented in cycle N+1 and bit k in cycle N+1+k.
- Gap cycles: prog_enable=0 and prog_data=0 in every non-SHIFT cycle. The downstream `Controller` samples prog_data only when prog_enable=1.
- start while busy: ignored; no restart, no counter effect.
- byte_valid in IDLE/DONE: ignored; no transfer, since byte_ready=0.
- Outputs are decoded from registered state only; no combinational path from byte_valid or start to any output except byte_ready, which depends on state alone.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with byte_valid=1 and start=1 → all outputs 0, bit_count 0, byte_ready 0.
- Back-to-back load at defaults: start, then bytes 0xA5,0x3C,0xFF,0x00,0x81,0x7E with valid always high → exactly 48 consecutive prog_enable=1 cycles, prog_data = LSB-first bit stream of those bytes, byte_ready high only in each byte's bit-7 cycle. done=1 the cycle after the final bit, bit_count=48.
- Stalled source: after byte 0 (last bit in cycle M), hold byte_valid=0 until edge M+3 → prog_enable=0 in cycles M+1..M+3, byte 1 bit0 in cycle M+4, stream otherwise unchanged.
- Partial final byte with TABLE_BITS=12: send 0x5A then 0xF3 → 12 bits emitted (0x5A LSB-first, then 1,1,0,0). Bits 4–7 of 0xF3 are not emitted, done=1, bit_count=12.
- Reset mid-load: assert rst_n=0 at the 3rd bit of byte 2 → next edge IDLE, prog_enable=0, bit_count=0. A new start plus 6 bytes completes normally with done=1.
- start handling: pulse start during SHIFT → ignored, bit_count continues. Pulse start in DONE → done drops next cycle, byte_ready=1, bit_count=0.

Source files
------------

// File: rtl/fsm_prog_loader.sv
// fsm_prog_loader: serialises transition-table bytes LSB-first onto the Controller programming port
module fsm_prog_loader #(
  parameter int STATE_COUNT = 8,
  parameter int STATE_WIDTH = $clog2(STATE_COUNT),
  parameter int TABLE_BITS  = 2 * STATE_COUNT * STATE_WIDTH
) (
  input  logic                            clock,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [7:0]                      byte_data,
  input  logic                            byte_valid,
  output logic                            byte_ready,
  output logic                            prog_enable,
  output logic                            prog_data,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(TABLE_BITS+1)-1:0] bit_count
);
  localparam int CW = $clog2(TABLE_BITS + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;
  state_t        state;
  logic [7:0]    shreg;
  logic [3:0]    bits_left;
  logic [3:0]    load_bits;
  logic [CW-1:0] cnt_next;
  logic [CW+3:0] remaining;
  logic          last_bit;
  // a byte loaded at a SHIFT byte boundary counts the bit leaving on the same edge
  always_comb begin
    cnt_next   = state == SHIFT ? bit_count + CW'(1) : bit_count;
    remaining  = (CW+4)'(TABLE_BITS) - {4'd0, cnt_next};
    load_bits  = remaining > (CW+4)'(8) ? 4'd8 : remaining[3:0];
    last_bit   = bit_count == CW'(TABLE_BITS - 1);
    byte_ready = state == WAIT_BYTE || (state == SHIFT && bits_left == 4'd1 && !last_bit);
  end
  assign prog_data = shreg[0];
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bits_left   <= '0;
      bit_count   <= '0;
      prog_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state     <= WAIT_BYTE;
          bit_count <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
        end
        WAIT_BYTE: if (byte_valid) begin
          state       <= SHIFT;
          shreg       <= byte_data;
          bits_left   <= load_bits;
          prog_enable <= 1'b1;
        end
        SHIFT: begin
          bit_count <= bit_count + CW'(1);
          bits_left <= bits_left - 4'd1;
          shreg     <= shreg >> 1;
          if (last_bit) begin
            state       <= DONE;
            shreg       <= '0;
            prog_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else if (bits_left == 4'd1) begin
            if (byte_valid) begin
              shreg     <= byte_data;
              bits_left <= load_bits;
            end else begin
              state       <= WAIT_BYTE;
              shreg       <= '0;
              prog_enable <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fsm_prog_loader.sv
// tb_fsm_prog_loader: randomized loads checked cycle by cycle against a byte-schedule model
module tb_fsm_prog_loader;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       ready_a, pe_a, pd_a, busy_a, done_a;
  logic [5:0] bc_a;
  logic       ready_b, pe_b, pd_b, busy_b, done_b;
  logic [3:0] bc_b;
  int         checks = 0, errors = 0;
  logic [7:0] ld_bytes [8];
  int         ld_stall [8];

  always #5 clk = ~clk;

  fsm_prog_loader dut_a (
    .clock(clk), .rst_n(rst_n), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(ready_a), .prog_enable(pe_a), .prog_data(pd_a), .busy(busy_a), .done(done_a),
    .bit_count(bc_a)
  );

  fsm_prog_loader #(.TABLE_BITS(12)) dut_b (
    .clock(clk), .rst_n(rst_n), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(ready_b), .prog_enable(pe_b), .prog_data(pd_b), .busy(busy_b), .done(done_b),
    .bit_count(bc_b)
  );

  // Byte i is accepted at edge t[i]; its bit j appears in the cycle after edge t[i]+j.
  // The source holds byte i valid early, then drops valid for ld_stall[i] edges past the first chance.
  task automatic run_load(input bit b, input int abort_bit, input int start_bit);
    int   tbits, nb, last, ca, sp, fin, i, lo, bc, c;
    int   t [8];
    logic x_pe, x_pd, x_r, x_busy, x_done;
    logic o_pe, o_pd, o_r, o_busy, o_done;
    int   o_bc;
    tbits = b ? 12 : 48;
    nb    = (tbits + 7) / 8;
    t[0]  = 1 + ld_stall[0];
    for (int k = 1; k < nb; k++) t[k] = t[k-1] + 8 + ld_stall[k];
    last = t[nb-1] + (tbits - 1) % 8;
    ca   = abort_bit >= 0 ? t[abort_bit/8] + abort_bit % 8 : -1;
    sp   = start_bit >= 0 ? t[start_bit/8] + start_bit % 8 + 1 : -1;
    fin  = ca >= 0 ? ca + 1 : last + 2;
    for (int e = 0; e <= fin; e++) begin
      start = e == 0 || e == sp;
      rst_n = !(ca >= 0 && e == ca + 1);
      i = 0;
      while (i < nb && t[i] < e) i++;
      if (i == nb || e == 0) begin
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
      end else begin
        lo = i == 0 ? 1 : t[i-1] + 8;
        byte_valid = !(e >= lo && e < t[i]);
        byte_data  = byte_valid ? ld_bytes[i] : 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      o_pe = b ? pe_b : pe_a;
      o_pd = b ? pd_b : pd_a;
      o_r = b ? ready_b : ready_a;
      o_busy = b ? busy_b : busy_a;
      o_done = b ? done_b : done_a;
      o_bc = b ? int'(bc_b) : int'(bc_a);
      x_pe = 1'b0; x_pd = 1'b0; x_r = 1'b0; x_busy = 1'b0; x_done = 1'b0; bc = 0;
      if (!(ca >= 0 && e == ca + 1)) begin
        for (int k = 0; k < tbits; k++) begin
          c = t[k/8] + k % 8;
          if (c == e) begin
            x_pe = 1'b1;
            x_pd = ld_bytes[k/8][k%8];
          end
          if (c < e) bc++;
        end
        x_r = e < t[0];
        for (int k = 1; k < nb; k++) if (e >= t[k-1] + 7 && e < t[k]) x_r = 1'b1;
        x_busy = e <= last;
        x_done = e > last;
      end
      checks += 6;
      if (o_pe !== x_pe) begin errors++; $display("FAIL prog_enable cyc %0d: got %b exp %b", e, o_pe, x_pe); end
      if (o_pd !== x_pd) begin errors++; $display("FAIL prog_data cyc %0d: got %b exp %b", e, o_pd, x_pd); end
      if (o_r !== x_r) begin errors++; $display("FAIL byte_ready cyc %0d: got %b exp %b", e, o_r, x_r); end
      if (o_busy !== x_busy) begin errors++; $display("FAIL busy cyc %0d: got %b exp %b", e, o_busy, x_busy); end
      if (o_done !== x_done) begin errors++; $display("FAIL done cyc %0d: got %b exp %b", e, o_done, x_done); end
      if (o_bc !== bc) begin errors++; $display("FAIL bit_count cyc %0d: got %0d exp %0d", e, o_bc, bc); end
    end
    start = 1'b0;
    byte_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic fill_random(input int max_stall);
    for (int k = 0; k < 8; k++) begin
      ld_bytes[k] = 8'($urandom);
      ld_stall[k] = $urandom_range(0, max_stall);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; byte_valid = 1'b1; byte_data = 8'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL reset byte_ready: got %b exp 0", ready_a); end
    if (pe_a !== 1'b0) begin errors++; $display("FAIL reset prog_enable: got %b exp 0", pe_a); end
    if (pd_a !== 1'b0) begin errors++; $display("FAIL reset prog_data: got %b exp 0", pd_a); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset busy: got %b exp 0", busy_a); end
    if (done_a !== 1'b0) begin errors++; $display("FAIL reset done: got %b exp 0", done_a); end
    if (bc_a !== 6'd0) begin errors++; $display("FAIL reset bit_count: got %0d exp 0", bc_a); end
    rst_n = 1'b1; start = 1'b0; byte_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    checks += 2;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL idle busy: got %b exp 0", busy_a); end
    if (pe_a !== 1'b0) begin errors++; $display("FAIL idle prog_enable: got %b exp 0", pe_a); end
  endtask

  task automatic test_back_to_back;
    ld_bytes[0] = 8'hA5; ld_bytes[1] = 8'h3C; ld_bytes[2] = 8'hFF;
    ld_bytes[3] = 8'h00; ld_bytes[4] = 8'h81; ld_bytes[5] = 8'h7E;
    for (int k = 0; k < 8; k++) ld_stall[k] = 0;
    run_load(1'b0, -1, -1);
  endtask

  task automatic test_stall;
    fill_random(0);
    ld_stall[1] = 3;
    run_load(1'b0, -1, -1);
  endtask

  task automatic test_start_in_shift;
    fill_random(0);
    run_load(1'b0, -1, 20);
  endtask

  task automatic test_random_restart;
    repeat (4) begin
      fill_random(3);
      run_load(1'b0, -1, $urandom_range(0, 1) ? $urandom_range(0, 46) : -1);
    end
  endtask

  task automatic test_reset_mid_load;
    fill_random(1);
    run_load(1'b0, 18, -1);
    fill_random(0);
    run_load(1'b0, -1, -1);
  endtask

  task automatic test_partial_byte;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ld_bytes[0] = 8'h5A; ld_bytes[1] = 8'hF3;
    for (int k = 0; k < 8; k++) ld_stall[k] = 0;
    run_load(1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_start_in_shift();
    test_random_restart();
    test_reset_mid_load();
    test_partial_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
